mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single external memory bus between the Icache refill path and the Dcache refill/writeback path. A registered FSM grants one requester at a time and runs a fixed-length ascending burst of 32-bit beats. It returns read data beat by beat and pulses a completion strobe. It sits between both caches and the memory port. `busy_o` feeds flow control so it can hold miss stalls.

## Interface
Parameters:
- `BURST_LEN`, 4: beats per burst; power of two, ≥2.
- `CNT_W`, $clog2(BURST_LEN): beat counter width (derived; do not override).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `Icache_req_i` in 1: Icache burst read request; held until `Icache_done_o`.
- `Icache_addr_i` in 32: Icache miss address.
- `Icache_rdata_o` out 32: returned read word.
- `Icache_rvalid_o` out 1: `Icache_rdata_o` valid this cycle.
- `Icache_done_o` out 1: one-cycle burst-complete pulse.
- `Dcache_req_i` in 1: Dcache burst request; held until `Dcache_done_o`.
- `Dcache_we_i` in 1: 1 = write burst, 0 = read burst; stable while `Dcache_req_i` is high.
- `Dcache_addr_i` in 32: Dcache burst address.
- `Dcache_wdata_i` in 32: write word for beat `Dcache_beat_o`.
- `Dcache_beat_o` out CNT_W: current beat index.
- `Dcache_wack_o` out 1: current write beat accepted by memory.
- `Dcache_rdata_o` out 32: returned read word.
- `Dcache_rvalid_o` out 1: `Dcache_rdata_o` valid this cycle.
- `Dcache_done_o` out 1: one-cycle burst-complete pulse.
- `mem_req_o` out 1: beat request to memory.
- `mem_we_o` out 1: beat is a write.
- `mem_addr_o` out 32: beat address.
- `mem_wdata_o` out 32: beat write data.
- `mem_ready_i` in 1: memory accepts/completes the beat this cycle.
- `mem_rdata_i` in 32: read data, valid when `mem_ready_i` is high on a read.
- `busy_o` out 1: FSM is not in IDLE.

## Operation
- States: IDLE, GNT_I, GNT_D, DONE.
- IDLE:
  - If either request is high, latch the winner, its `we`, and its aligned base address: addr with bits [CNT_W+1:0] cleared. Clear the beat counter.
  - Go to GNT_I or GNT_D.
- GNT_x:
  - `mem_req_o`=1.
  - `mem_addr_o` = base | (cnt<<2).
  - `mem_we_o` = latched we. It is always 0 in GNT_I.
- GNT_D write:
  - `mem_wdata_o` = `Dcache_wdata_i`.
  - `Dcache_beat_o` = cnt.
  - `Dcache_wack_o` = `mem_ready_i` (combinational).
- Beat completion: a beat completes on any cycle with `mem_req_o` & `mem_ready_i`.
  - cnt increments.
  - On a read, `mem_rdata_i` is registered into the granted requester's rdata, and its rvalid is pulsed the next cycle.
- Last beat (cnt == BURST_LEN-1 completing): go to DONE.
- DONE:
  - Pulse the granted requester's `done_o` for one cycle.
  - Requests are ignored.
  - Next state is IDLE.
- Requester obligations:
  - Drop its req no later than the clock edge that ends DONE.
  - Keep addr and we stable while requesting.
- Address arithmetic: addresses are 32-bit and ascending. There is no critical-word-first and no wrap within the burst.
- Outputs are 0 in IDLE and DONE except `done_o`, the last `rvalid`/`rdata`, and `busy_o`.
- Reset: state IDLE, cnt 0, every output 0, `rdata_o` 32'h0. A burst in flight is abandoned with no done pulse.
- No request while in IDLE: stay in IDLE.

## Timing
- Grant latency: a request sampled in IDLE at edge N gives `mem_req_o`=1 from cycle N+1.
- Zero-wait memory: a burst occupies BURST_LEN cycles in GNT_x, then 1 cycle in DONE. The earliest next grant decision is the IDLE cycle after DONE.
- Wait states: `mem_ready_i` low holds cnt, address and data unchanged, with no limit.
- Read data: `rvalid_o` for beat k asserts the cycle after beat k completes. The last beat's `rvalid_o` coincides with `done_o`.
- Write ack: `Dcache_wack_o` is combinational in the completion cycle. `Dcache_beat_o` advances on the following edge.
- Simultaneous requests in IDLE: fixed priority, Dcache wins. Icache is granted after Dcache's DONE, provided it is still requesting.
- Request arriving while busy: waits in its requester; it is never dropped or merged.

## Configuration
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, Dcache > Icache.
- `ARB_ROUND_ROBIN_EN` defined: a 1-bit last-grant register is added.
  - Reset value is Icache.
  - On a tie, the requester not granted last wins; the first tie after reset goes to Dcache.
  - A lone requester is always granted immediately.
  - The register updates on each grant.

## Test plan
- Icache alone, addr 0x1000_0014, BURST_LEN 4, `mem_ready_i` tied 1:
  - `mem_addr_o` = 0x1000_0010/14/18/1C on consecutive cycles.
  - Four `Icache_rvalid_o` pulses carrying the returned words.
  - `Icache_done_o` one cycle with the last rvalid.
  - `busy_o` high for 5 cycles.
- Dcache write, addr 0x2000_0040, wdata = 0xA0+beat, `mem_ready_i` toggling 1/0:
  - `mem_we_o`=1 throughout.
  - `mem_wdata_o` sequence 0xA0..0xA3.
  - `Dcache_wack_o` on each ready cycle only.
  - `Dcache_done_o` after the 4th accepted beat.
- Both requests in the same IDLE cycle, macro off:
  - Dcache burst first, then Icache burst.
  - Repeat the tie: Dcache wins again.
- Same stimulus with `ARB_ROUND_ROBIN_EN` defined:
  - First tie grants Dcache, second tie grants Icache.
- `rst_n` low in the middle of beat 2 of a Dcache read:
  - All outputs 0 immediately.
  - No `Dcache_done_o`.
  - After release, a new Icache request is granted one cycle after it is sampled.
- `mem_ready_i` held 0 for 10 cycles on beat 0:
  - `mem_addr_o` and `mem_req_o` stable.
  - No rvalid.
  - The burst resumes correctly when ready rises.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one external memory bus between Icache refill reads and Dcache refill/writeback bursts.
// Latency: grant one cycle after a request is sampled in IDLE; BURST_LEN beats (plus wait states) then one DONE cycle.
// Backpressure: mem_ready_i low stalls the current beat indefinitely; a losing requester holds its req. ARB_ROUND_ROBIN_EN enables round-robin ties.
module mem_bus_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = $clog2(BURST_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Icache_req_i,
  input  logic [31:0]      Icache_addr_i,
  output logic [31:0]      Icache_rdata_o,
  output logic             Icache_rvalid_o,
  output logic             Icache_done_o,
  input  logic             Dcache_req_i,
  input  logic             Dcache_we_i,
  input  logic [31:0]      Dcache_addr_i,
  input  logic [31:0]      Dcache_wdata_i,
  output logic [CNT_W-1:0] Dcache_beat_o,
  output logic             Dcache_wack_o,
  output logic [31:0]      Dcache_rdata_o,
  output logic             Dcache_rvalid_o,
  output logic             Dcache_done_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_ready_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Clears the byte offset and the beat index so every burst starts on its natural boundary.
  localparam logic [31:0] BASE_MASK = ~((32'd1 << (CNT_W + 2)) - 32'd1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      base;
  logic             we_q;
  logic             gnt_d;
  logic             pick_d;
  logic             any_req;
  logic             in_gnt;
  logic             wr_beat;
  logic             last_beat;

  assign any_req   = Icache_req_i | Dcache_req_i;
  assign in_gnt    = (state == GNT_I) || (state == GNT_D);
  assign wr_beat   = (state == GNT_D) && we_q;
  assign last_beat = (cnt == CNT_W'(BURST_LEN - 1));

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // On a tie the requester that was not served last wins; a lone requester always wins.
  always_comb begin
    pick_d = Dcache_req_i && (!Icache_req_i || !last_d);
  end

  // Remember who got the bus on every grant; reset favours Dcache on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_d <= pick_d;
    end
  end
`else
  // Fixed priority: Dcache always beats Icache.
  always_comb begin
    pick_d = Dcache_req_i;
  end
`endif

  // Burst sequencer: grant in IDLE, step beats on mem_ready_i, one DONE cycle, back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= 32'h0;
      we_q  <= 1'b0;
      gnt_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= pick_d ? GNT_D : GNT_I;
            gnt_d <= pick_d;
            we_q  <= pick_d & Dcache_we_i;
            base  <= (pick_d ? Dcache_addr_i : Icache_addr_i) & BASE_MASK;
            cnt   <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ready_i) begin
            cnt <= cnt + CNT_W'(1);
            if (last_beat) begin
              state <= DONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Capture read data of each completed read beat for the granted cache; rvalid follows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Icache_rdata_o  <= 32'h0;
      Icache_rvalid_o <= 1'b0;
      Dcache_rdata_o  <= 32'h0;
      Dcache_rvalid_o <= 1'b0;
    end else begin
      Icache_rvalid_o <= (state == GNT_I) && mem_ready_i;
      Dcache_rvalid_o <= (state == GNT_D) && !we_q && mem_ready_i;
      if ((state == GNT_I) && mem_ready_i) begin
        Icache_rdata_o <= mem_rdata_i;
      end
      if ((state == GNT_D) && !we_q && mem_ready_i) begin
        Dcache_rdata_o <= mem_rdata_i;
      end
    end
  end

  assign busy_o        = (state != IDLE);
  assign mem_req_o     = in_gnt;
  assign mem_we_o      = wr_beat;
  assign mem_addr_o    = in_gnt ? (base | {{(30 - CNT_W){1'b0}}, cnt, 2'b00}) : 32'h0;
  assign mem_wdata_o   = wr_beat ? Dcache_wdata_i : 32'h0;
  assign Dcache_beat_o = wr_beat ? cnt : '0;
  assign Dcache_wack_o = wr_beat && mem_ready_i;
  assign Icache_done_o = (state == DONE) && !gnt_d;
  assign Dcache_done_o = (state == DONE) && gnt_d;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: self-checking bench for mem_bus_arbiter using a burst-level scoreboard plus directed literal checks.
// Latency: model expects grant one cycle after sampling, rvalid one cycle after each read beat, done after the last beat.
// Backpressure: mem_ready_i driven always-high, toggling, or stalled for ten cycles on beat 0.
module tb_mem_bus_arbiter;

  localparam int BL = 4;
  localparam int CW = $clog2(BL);

  typedef struct {
    bit          d;
    bit          we;
    logic [31:0] base;
  } burst_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          Icache_req_i = 1'b0;
  logic [31:0]   Icache_addr_i = 32'h0;
  logic [31:0]   Icache_rdata_o;
  logic          Icache_rvalid_o;
  logic          Icache_done_o;
  logic          Dcache_req_i = 1'b0;
  logic          Dcache_we_i = 1'b0;
  logic [31:0]   Dcache_addr_i = 32'h0;
  logic [31:0]   Dcache_wdata_i;
  logic [CW-1:0] Dcache_beat_o;
  logic          Dcache_wack_o;
  logic [31:0]   Dcache_rdata_o;
  logic          Dcache_rvalid_o;
  logic          Dcache_done_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_ready_i = 1'b1;
  logic [31:0]   mem_rdata_i;
  logic          busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rmode = 0;
  int stall_done = 0;

  // Model state (written only by the compare process, except bq and last_d_tb).
  burst_t      bq[$];
  int          bhead = 0;
  int          beat = 0;
  bit          ev_i = 0, ev_d = 0, ed_i = 0, ed_d = 0, prev_req = 0;
  logic [31:0] erd_i = 0, erd_d = 0, ea;
  burst_t      h;
  logic [31:0] addr_log[$];
  logic [31:0] wdata_log[$];
  bit          done_order[$];
  int          req_log[$];
  int          busy_cyc = 0, rv_i = 0, rv_d = 0, dn_i = 0, dn_d = 0, wack_cnt = 0, stall_cnt = 0;
  int          last_rv_i = -1, done_cyc_i = -2;
  bit          last_d_tb = 0;

  function automatic logic [31:0] rfn(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  assign mem_rdata_i    = rfn(mem_addr_o);
  assign Dcache_wdata_i = 32'h0000_00A0 + 32'(Dcache_beat_o);

  mem_bus_arbiter #(.BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .Icache_req_i(Icache_req_i), .Icache_addr_i(Icache_addr_i),
    .Icache_rdata_o(Icache_rdata_o), .Icache_rvalid_o(Icache_rvalid_o), .Icache_done_o(Icache_done_o),
    .Dcache_req_i(Dcache_req_i), .Dcache_we_i(Dcache_we_i), .Dcache_addr_i(Dcache_addr_i),
    .Dcache_wdata_i(Dcache_wdata_i), .Dcache_beat_o(Dcache_beat_o), .Dcache_wack_o(Dcache_wack_o),
    .Dcache_rdata_o(Dcache_rdata_o), .Dcache_rvalid_o(Dcache_rvalid_o), .Dcache_done_o(Dcache_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory ready pattern: 0 = always ready, 1 = toggling, 2 = ten wait cycles on the first beat.
  always @(posedge clk) begin
    #1;
    if (rmode == 1) mem_ready_i = ~mem_ready_i;
    else if (rmode == 2 && mem_req_o && stall_done < 10) begin
      mem_ready_i = 1'b0;
      stall_done++;
    end else mem_ready_i = 1'b1;
    if (rmode != 2) stall_done = 0;
  end

  // Compare process: scoreboard of expected bursts, checked every cycle at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      bhead = bq.size(); beat = 0;
      ev_i = 0; ev_d = 0; ed_i = 0; ed_d = 0; prev_req = 0;
    end else begin
      chk("i_rvalid", 32'(Icache_rvalid_o), 32'(ev_i));
      if (ev_i) chk("i_rdata", Icache_rdata_o, erd_i);
      chk("d_rvalid", 32'(Dcache_rvalid_o), 32'(ev_d));
      if (ev_d) chk("d_rdata", Dcache_rdata_o, erd_d);
      chk("i_done", 32'(Icache_done_o), 32'(ed_i));
      chk("d_done", 32'(Dcache_done_o), 32'(ed_d));
      if (Icache_rvalid_o) begin rv_i++; last_rv_i = cyc; end
      if (Dcache_rvalid_o) rv_d++;
      if (Icache_done_o) begin dn_i++; done_cyc_i = cyc; done_order.push_back(1'b0); end
      if (Dcache_done_o) begin dn_d++; done_order.push_back(1'b1); end
      if (busy_o) busy_cyc++;
      if (Dcache_wack_o) wack_cnt++;
      if (mem_req_o && !prev_req) req_log.push_back(cyc);
      prev_req = mem_req_o;
      ev_i = 0; ev_d = 0; ed_i = 0; ed_d = 0;
      if (bhead < bq.size() && mem_req_o) begin
        h  = bq[bhead];
        ea = h.base + 32'(beat) * 32'd4;
        chk("mem_addr", mem_addr_o, ea);
        chk("mem_we", 32'(mem_we_o), 32'(h.we));
        if (h.d && h.we) begin
          chk("mem_wdata", mem_wdata_o, 32'h0000_00A0 + 32'(beat));
          chk("d_beat", 32'(Dcache_beat_o), 32'(beat));
          chk("d_wack", 32'(Dcache_wack_o), 32'(mem_ready_i));
        end else begin
          chk("rd_wdata", mem_wdata_o, 32'h0);
          chk("rd_wack", 32'(Dcache_wack_o), 32'h0);
          chk("rd_beat", 32'(Dcache_beat_o), 32'h0);
        end
        if (mem_ready_i) begin
          addr_log.push_back(mem_addr_o);
          wdata_log.push_back(mem_wdata_o);
          if (!h.we) begin
            if (h.d) begin ev_d = 1; erd_d = rfn(ea); end
            else begin ev_i = 1; erd_i = rfn(ea); end
          end
          beat++;
          if (beat == BL) begin
            beat = 0; bhead++;
            if (h.d) ed_d = 1; else ed_i = 1;
          end
        end else stall_cnt++;
      end else begin
        chk("idle_req", 32'(mem_req_o), 32'h0);
        chk("idle_addr", mem_addr_o, 32'h0);
        chk("idle_we_wack", {30'h0, mem_we_o, Dcache_wack_o}, 32'h0);
        chk("idle_wdata", mem_wdata_o, 32'h0);
      end
    end
  end

  task automatic exp_burst(input bit d, input bit we, input logic [31:0] a);
    burst_t b;
    b.d = d; b.we = we;
    b.base = a - (a % (BL * 4));
    bq.push_back(b);
  endtask

  // Arbitration rule of the model: returns 1 when Dcache should win.
  task automatic arb(input bit ir, input bit dr, output bit win_d);
    if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_d = !last_d_tb;
`else
      win_d = 1'b1;
`endif
    end else win_d = dr;
    last_d_tb = win_d;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((Icache_req_i || Dcache_req_i || busy_o || bhead < bq.size()) && n < budget) begin
      @(negedge clk);
      n++;
      if (Icache_done_o) Icache_req_i = 1'b0;
      if (Dcache_done_o) Dcache_req_i = 1'b0;
    end
    chk("wait_idle_timeout", 32'(n < budget), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0; last_d_tb = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1a[4] = '{32'h1000_0010, 32'h1000_0014, 32'h1000_0018, 32'h1000_001C};
    logic [31:0] t2w[4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
`ifdef ARB_ROUND_ROBIN_EN
    bit t3o[3] = '{1'b1, 1'b0, 1'b1};
`else
    bit t3o[3] = '{1'b1, 1'b1, 1'b0};
`endif
    int s_a, s_w, s_b, s_rv, s_rq, s_wk, s_dd, s_o, s_st, s_di, t_req, n;
    bit w;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_i_rdata", Icache_rdata_o, 32'h0);
    chk("rst_d_rdata", Dcache_rdata_o, 32'h0);
    chk("rst_flags", {26'h0, Icache_rvalid_o, Icache_done_o, Dcache_rvalid_o, Dcache_done_o, mem_we_o, Dcache_wack_o}, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: Icache alone, zero-wait memory.
    s_a = addr_log.size(); s_b = busy_cyc; s_rv = rv_i; s_rq = req_log.size(); s_di = dn_i;
    exp_burst(0, 0, 32'h1000_0014);
    Icache_addr_i = 32'h1000_0014; Icache_req_i = 1'b1; t_req = cyc;
    wait_idle(40);
    chk("t1_nreq", 32'(req_log.size() - s_rq), 32'h1);
    if (req_log.size() > s_rq) chk("t1_grant_latency", 32'(req_log[s_rq] - t_req), 32'h1);
    chk("t1_nbeats", 32'(addr_log.size() - s_a), 32'h4);
    if (addr_log.size() >= s_a + 4)
      for (int k = 0; k < 4; k++) chk("t1_addr", addr_log[s_a + k], t1a[k]);
    chk("t1_busy_cycles", 32'(busy_cyc - s_b), 32'h5);
    chk("t1_rvalid_count", 32'(rv_i - s_rv), 32'h4);
    chk("t1_done_count", 32'(dn_i - s_di), 32'h1);
    chk("t1_done_with_last_rvalid", 32'(done_cyc_i), 32'(last_rv_i));

    // T2: Dcache write with toggling ready.
    s_w = wdata_log.size(); s_wk = wack_cnt; s_dd = dn_d; s_rv = rv_d;
    rmode = 1;
    exp_burst(1, 1, 32'h2000_0040);
    Dcache_addr_i = 32'h2000_0040; Dcache_we_i = 1'b1; Dcache_req_i = 1'b1;
    wait_idle(60);
    rmode = 0;
    chk("t2_nbeats", 32'(wdata_log.size() - s_w), 32'h4);
    if (wdata_log.size() >= s_w + 4)
      for (int k = 0; k < 4; k++) chk("t2_wdata", wdata_log[s_w + k], t2w[k]);
    chk("t2_wack_count", 32'(wack_cnt - s_wk), 32'h4);
    chk("t2_done_count", 32'(dn_d - s_dd), 32'h1);
    chk("t2_no_rvalid", 32'(rv_d - s_rv), 32'h0);
    Dcache_we_i = 1'b0;

    // T3: simultaneous requests, then Dcache re-requests straight after its DONE.
    reset_pulse();
    s_o = done_order.size();
    Dcache_addr_i = 32'h3000_0000; Icache_addr_i = 32'h4000_0024;
    arb(1, 1, w); exp_burst(w, 0, w ? 32'h3000_0000 : 32'h4000_0024);
    arb(1, 1, w); exp_burst(w, 0, w ? 32'h3000_0000 : 32'h4000_0024);
    if (w) begin arb(1, 0, w); end else begin arb(0, 1, w); end
    exp_burst(w, 0, w ? 32'h3000_0000 : 32'h4000_0024);
    Icache_req_i = 1'b1; Dcache_req_i = 1'b1;
    n = 0;
    while (!Dcache_done_o && n < 40) begin @(negedge clk); n++; end
    chk("t3_first_done_timeout", 32'(n < 40), 32'h1);
    Dcache_req_i = 1'b0;
    @(posedge clk); #1;
    Dcache_req_i = 1'b1;
    wait_idle(80);
    chk("t3_ndone", 32'(done_order.size() - s_o), 32'h3);
    if (done_order.size() >= s_o + 3)
      for (int k = 0; k < 3; k++) chk("t3_grant_order", 32'(done_order[s_o + k]), 32'(t3o[k]));

    // T4: reset in the middle of beat 2 of a Dcache read.
    s_dd = dn_d;
    exp_burst(1, 0, 32'h5000_0008);
    Dcache_addr_i = 32'h5000_0008; Dcache_req_i = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0; Dcache_req_i = 1'b0; last_d_tb = 0;
    #1;
    chk("t4_req", 32'(mem_req_o), 32'h0);
    chk("t4_addr", mem_addr_o, 32'h0);
    chk("t4_busy", 32'(busy_o), 32'h0);
    chk("t4_d_rdata", Dcache_rdata_o, 32'h0);
    chk("t4_flags", {28'h0, Dcache_rvalid_o, Dcache_done_o, Dcache_wack_o, 1'b0}, 32'h0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_rq = req_log.size();
    exp_burst(0, 0, 32'h1000_0040);
    Icache_addr_i = 32'h1000_0040; Icache_req_i = 1'b1; t_req = cyc;
    wait_idle(40);
    chk("t4_no_d_done", 32'(dn_d - s_dd), 32'h0);
    chk("t4_nreq", 32'(req_log.size() - s_rq), 32'h1);
    if (req_log.size() > s_rq) chk("t4_grant_latency", 32'(req_log[s_rq] - t_req), 32'h1);

    // T5: ten wait states on beat 0.
    rmode = 2;
    @(posedge clk); #1;
    s_a = addr_log.size(); s_b = busy_cyc; s_rv = rv_i; s_st = stall_cnt;
    exp_burst(0, 0, 32'h6000_0004);
    Icache_addr_i = 32'h6000_0004; Icache_req_i = 1'b1;
    wait_idle(80);
    rmode = 0;
    chk("t5_stall_cycles", 32'(stall_cnt - s_st), 32'd10);
    chk("t5_busy_cycles", 32'(busy_cyc - s_b), 32'd15);
    chk("t5_rvalid_count", 32'(rv_i - s_rv), 32'h4);
    chk("t5_nbeats", 32'(addr_log.size() - s_a), 32'h4);
    if (addr_log.size() >= s_a + 4) begin
      chk("t5_first_addr", addr_log[s_a], 32'h6000_0000);
      chk("t5_last_addr", addr_log[s_a + 3], 32'h6000_000C);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
